// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and registered lookup.
// Ports: clk/reset (async active-low); lookup_valid/lookup_pc -> registered pred_valid,
// btb_found, branch_prediction, btb_target one cycle later; upd_valid/upd_pc/upd_taken/
// upd_target/upd_mispredict train the table; upd_count/mispredict_count count updates.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic        pred_valid,
  output logic        btb_found,
  output logic        branch_prediction,
  output logic [31:0] btb_target,
  output logic [31:0] upd_count,
  output logic [31:0] mispredict_count
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  logic          r_valid [ENTRIES];
  logic [TW-1:0] r_tag   [ENTRIES];
  logic [31:0]   r_tgt   [ENTRIES];
  logic [1:0]    r_ctr   [ENTRIES];
  logic          r_pred_valid, r_found, r_pred;
  logic [31:0]   r_target, r_upd_count, r_mis_count;
  logic [IW-1:0] w_lidx, w_uidx;
  logic [TW-1:0] w_ltag, w_utag;
  logic          w_lhit, w_uhit;
  logic [1:0]    w_ctr_next;
  always_comb begin
    w_lidx     = lookup_pc[IW+1:2];
    w_ltag     = lookup_pc[31:IW+2];
    w_uidx     = upd_pc[IW+1:2];
    w_utag     = upd_pc[31:IW+2];
    w_lhit     = r_valid[w_lidx] && r_tag[w_lidx] == w_ltag;
    w_uhit     = r_valid[w_uidx] && r_tag[w_uidx] == w_utag;
    w_ctr_next = upd_taken ? (r_ctr[w_uidx] == 2'b11 ? 2'b11 : r_ctr[w_uidx] + 2'b01)
                           : (r_ctr[w_uidx] == 2'b00 ? 2'b00 : r_ctr[w_uidx] - 2'b01);
  end
  // Lookup reads the table before this edge's update lands, so a same-cycle
  // update to the same index is not visible until the next lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= 2'b01;
      end
      r_pred_valid <= 1'b0;
      r_found      <= 1'b0;
      r_pred       <= 1'b0;
      r_target     <= '0;
      r_upd_count  <= '0;
      r_mis_count  <= '0;
    end else begin
      r_pred_valid <= lookup_valid;
      r_found      <= lookup_valid && w_lhit;
      r_pred       <= lookup_valid && w_lhit && r_ctr[w_lidx][1];
      r_target     <= (lookup_valid && w_lhit) ? r_tgt[w_lidx] : 32'h0;
      if (upd_valid) begin
        r_upd_count <= r_upd_count + 32'd1;
        if (upd_mispredict) r_mis_count <= r_mis_count + 32'd1;
        if (w_uhit) begin
          r_ctr[w_uidx] <= w_ctr_next;
          if (upd_taken) r_tgt[w_uidx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_uidx] <= 1'b1;
          r_tag[w_uidx]   <= w_utag;
          r_tgt[w_uidx]   <= upd_target;
          r_ctr[w_uidx]   <= 2'b10;
        end
      end
    end
  end
  assign pred_valid        = r_pred_valid;
  assign btb_found         = r_found;
  assign branch_prediction = r_pred;
  assign btb_target        = r_target;
  assign upd_count         = r_upd_count;
  assign mispredict_count  = r_mis_count;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for the branch predictor, reference table model in the bench.
module tb_branch_predictor;
  logic        clk, reset, lookup_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        pred_valid, btb_found, branch_prediction;
  logic [31:0] btb_target, upd_count, mispredict_count;
  logic [34:0] got, exp;
  logic [34:0] q [$];
  logic        m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];
  logic [31:0] m_upd, m_mis;
  int errors = 0, checks = 0;
  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .pred_valid(pred_valid), .btb_found(btb_found),
    .branch_prediction(branch_prediction), .btb_target(btb_target),
    .upd_count(upd_count), .mispredict_count(mispredict_count)
  );
  assign got = {pred_valid, btb_found, branch_prediction, btb_target};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
    end
    m_upd = '0; m_mis = '0;
    q.delete();
  endtask
  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                       input logic um);
    int li, ui;
    logic h;
    lookup_valid = lv; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_mispredict = um;
    li = int'(lpc[5:2]);
    h = m_v[li] && m_tag[li] == lpc[31:6];
    q.push_back(lv ? {1'b1, h, h & m_ctr[li][1], h ? m_tgt[li] : 32'h0} : 35'h0);
    if (uv) begin
      m_upd++;
      if (um) m_mis++;
      ui = int'(upc[5:2]);
      if (m_v[ui] && m_tag[ui] == upc[31:6]) begin
        if (ut) begin
          m_ctr[ui] = m_ctr[ui] == 2'b11 ? 2'b11 : m_ctr[ui] + 2'b01;
          m_tgt[ui] = utg;
        end else m_ctr[ui] = m_ctr[ui] == 2'b00 ? 2'b00 : m_ctr[ui] - 2'b01;
      end else if (ut) begin
        m_v[ui] = 1'b1; m_tag[ui] = upc[31:6]; m_tgt[ui] = utg; m_ctr[ui] = 2'b10;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== 35'h0 || upd_count !== 32'h0 || mispredict_count !== 32'h0) begin
      errors++;
      $display("FAIL reset got=%h cnt=%h/%h exp=0", got, upd_count, mispredict_count);
    end
    reset = 1'b1;
  endtask
  task automatic test_cold();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || got !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL cold got=%h exp=%h", got, exp);
    end
  endtask
  task automatic test_alloc();
    drive(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL alloc_idle got=%h exp=%h", got, exp); end
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || got !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL alloc_hit got=%h exp=%h", got, exp);
    end
  endtask
  task automatic test_saturation();
    logic [5:0] ops;
    ops = 6'b110000;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h100, ops[i], 32'h200, 1'b0);
      @(posedge clk); #1;
      exp = q.pop_front();
      drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL saturation step=%0d got=%h exp=%h", i, got, exp); end
      if (i == 3) begin
        checks++;
        if (got !== {3'b110, 32'h200}) begin
          errors++; $display("FAIL sat_floor got=%h exp=%h", got, {3'b110, 32'h200});
        end
      end
    end
    checks++;
    if (got !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL sat_retrain got=%h exp=%h", got, {3'b111, 32'h200});
    end
  endtask
  task automatic test_alias();
    logic [31:0] pcs [2];
    pcs[0] = 32'h100; pcs[1] = 32'h140;
    drive(1'b0, 32'h0, 1'b1, 32'h140, 1'b1, 32'h240, 1'b1);
    @(posedge clk); #1;
    exp = q.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, pcs[i], 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      exp = q.pop_front();
      checks++;
      if (got !== exp || btb_found !== (i == 1)) begin
        errors++; $display("FAIL alias pc=%h got=%h exp=%h", pcs[i], got, exp);
      end
    end
  endtask
  task automatic test_collision();
    drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h380, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || btb_found !== 1'b0) begin
      errors++; $display("FAIL collision_same got=%h exp=%h", got, exp);
    end
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || got !== {3'b111, 32'h380}) begin
      errors++; $display("FAIL collision_next got=%h exp=%h", got, exp);
    end
  endtask
  task automatic test_counts();
    logic [4:0] mis;
    logic [31:0] base_u, base_m;
    mis = 5'b01010;
    base_u = m_upd; base_m = m_mis;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h500 + 32'(i * 4), 1'b0, 32'h0, mis[i]);
      @(posedge clk); #1;
      exp = q.pop_front();
      checks++;
      if (upd_count !== m_upd || mispredict_count !== m_mis) begin
        errors++; $display("FAIL counts step=%0d got=%h/%h exp=%h/%h", i, upd_count, mispredict_count, m_upd, m_mis);
      end
    end
    checks++;
    if (upd_count - base_u !== 32'd5 || mispredict_count - base_m !== 32'd2) begin
      errors++; $display("FAIL counts_delta got=%0d/%0d exp=5/2", upd_count - base_u, mispredict_count - base_m);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h400, 1'b1, 32'h999, 1'b1);
    @(posedge clk); #1;
    exp = q.pop_front();
    drive(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || btb_found !== 1'b0 || upd_count !== m_upd) begin
      errors++; $display("FAIL upd_ignored got=%h cnt=%h exp=%h cnt=%h", got, upd_count, exp, m_upd);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h104; pcs[3] = 32'h1100; pcs[4] = 32'h300;
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      exp = q.pop_front();
      checks++;
      if (got !== exp || upd_count !== m_upd || mispredict_count !== m_mis) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h cnt=%h/%h exp=%h/%h", i, got, exp, upd_count, mispredict_count, m_upd, m_mis);
      end
    end
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 32'h300, 1'b1, 32'h100, 1'b1, 32'h700, 1'b1);
    @(posedge clk); #1;
    exp = q.pop_front();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (got !== 35'h0 || upd_count !== 32'h0 || mispredict_count !== 32'h0) begin
      errors++; $display("FAIL reset_mid got=%h cnt=%h/%h exp=0", got, upd_count, mispredict_count);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp = q.pop_front();
    checks++;
    if (got !== exp || pred_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i == 0 ? 32'h100 : 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      exp = q.pop_front();
      checks++;
      if (got !== exp || got !== {3'b100, 32'h0}) begin
        errors++; $display("FAIL reset_empty i=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_cold();
    test_alloc();
    test_saturation();
    test_alias();
    test_collision();
    test_counts();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of BTB entries (power of two, 4..64).
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have lookup_valid  input  1  fetch requests prediction for lookup_pc.
REQ-005 SHALL have lookup_pc  input  32  fetch PC, word aligned.
REQ-006 SHALL have upd_valid  input  1  resolved branch update from branch resolution stage.
REQ-007 SHALL have upd_pc  input  32  PC of resolved branch.
REQ-008 SHALL have upd_taken  input  1  actual branch outcome.
REQ-009 SHALL have upd_target  input  32  actual branch target.
REQ-010 SHALL have upd_mispredict  input  1  resolution flagged misprediction.
REQ-011 SHALL have pred_valid  output  1  prediction outputs valid this cycle.
REQ-012 SHALL have btb_found  output  1  lookup hit a valid entry with matching tag.
REQ-013 SHALL have branch_prediction  output  1  predict taken (hit and counter[1]==1).
REQ-014 SHALL have btb_target  output  32  predicted target; 0 when btb_found==0.
REQ-015 SHALL have upd_count  output  32  number of accepted updates.
REQ-016 SHALL have mispredict_count  output  32  number of updates with upd_mispredict==1.

Function
REQ-017 SHALL index with IDX = pc[log2(ENTRIES)+1:2] and tag with TAG = pc[31:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-018 SHALL hold per entry: valid (1), tag, target (32), 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-019 SHALL register lookup: outputs for lookup_pc presented at cycle N appear at cycle N+1 with pred_valid=1; pred_valid=0 when lookup_valid was 0, other outputs then 0.
REQ-020 SHALL report hit when entry[IDX].valid and entry[IDX].tag==TAG; on hit btb_target=entry target, branch_prediction=counter[1].
REQ-021 SHALL on update hit: taken -> counter saturating increment (11 stays 11), target overwritten with upd_target; not-taken -> saturating decrement (00 stays 00), target unchanged.
REQ-022 SHALL on update miss with upd_taken=1 allocate: valid=1, tag, target=upd_target, counter=10; replaces any prior occupant.
REQ-023 SHALL on update miss with upd_taken=0 leave the table unchanged.
REQ-024 SHALL, for lookup and update in the same cycle to the same index, return pre-update contents (read before write, no bypass).
REQ-025 SHALL increment upd_count on each cycle with upd_valid=1 and mispredict_count when additionally upd_mispredict=1; both wrap 0xFFFFFFFF -> 0.
REQ-026 SHALL ignore upd_* fields when upd_valid=0 and lookup_pc when lookup_valid=0.

Reset
REQ-027 SHALL, while reset==0, asynchronously clear all valid bits, set all counters to 01, clear targets and tags, and drive pred_valid, btb_found, branch_prediction, btb_target, upd_count, mispredict_count to 0.
REQ-028 SHALL discard any in-flight lookup when reset asserts mid-operation; first pred_valid after release reflects only post-release lookups.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-030 Cold lookup: after reset, lookup pc=0x100 -> next cycle pred_valid=1, btb_found=0, branch_prediction=0, btb_target=0.
REQ-031 Allocate and hit: update pc=0x100 taken target=0x200 -> lookup 0x100 gives btb_found=1, prediction=1 (counter 10), btb_target=0x200.
REQ-032 Saturation: from 10, three not-taken updates to 0x100 -> counter 00, prediction=0, btb_found=1; fourth stays 00; two taken updates -> 10, prediction=1.
REQ-033 Alias/conflict (ENTRIES=16): allocate 0x100 then taken update 0x140 (same index, different tag) -> lookup 0x100 misses, 0x140 hits with new target.
REQ-034 Same-cycle collision: lookup and allocating update both at 0x300 in one cycle -> that lookup reports btb_found=0; following lookup reports hit.
REQ-035 Counters/reset: 5 updates with 2 mispredicts -> upd_count=5, mispredict_count=2; preload upd_count 0xFFFFFFFF scenario wraps to 0; assert reset mid-lookup -> all outputs 0 immediately, table empty.
